fetch_queue_unit: RTL and testbench

Parametrised multi-issue instruction fetch front end. Requests FETCH_W consecutive instruction words per cycle from a 1-cycle-latency instruction memory port. Buffers them with their PCs in a QDEPTH-entry circular instruction queue. Presents up to FETCH_W instructions per cycle to decode through a valid/ready handshake. Branch redirect flushes the queue and any in-flight fetch.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue_unit_if.sv | 40 ++++
 rtl/fetch_queue_unit_instr_queue.sv | 70 +++++++
 rtl/fetch_queue_unit.sv | 118 +++++++++++
 tb/tb_fetch_queue_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package fetch_pkg;
   localparam int XLEN        = 16;
   localparam int ADDR_W      = 16;
   localparam int MAX_FETCH_W = 4;
   localparam logic [XLEN-1:0] NOP_INSTR = '0;

   typedef struct packed {
      logic [XLEN-1:0]   instr;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

   // Bit i set when more than i entries are available.
   function automatic logic [MAX_FETCH_W-1:0] thermo(input int unsigned cnt);
      logic [MAX_FETCH_W-1:0] m;
      for (int i = 0; i < MAX_FETCH_W; i++) m[i] = (cnt > unsigned'(i));
      return m;
   endfunction
endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: redirect, imem request/response, decode handshake.
// Perf counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_queue_unit_if #(
   parameter int XLEN    = fetch_pkg::XLEN,
   parameter int ADDR_W  = fetch_pkg::ADDR_W,
   parameter int FETCH_W = 2,
   parameter int QDEPTH  = 8
);
   logic                        redirect_valid;
   logic [ADDR_W-1:0]           redirect_pc;
   logic                        imem_req_valid;
   logic [ADDR_W-1:0]           imem_req_addr;
   logic [FETCH_W*XLEN-1:0]     imem_rsp_data;
   logic [FETCH_W-1:0]          dec_valid;
   logic [FETCH_W*XLEN-1:0]     dec_instr;
   logic [FETCH_W*ADDR_W-1:0]   dec_pc;
   logic                        dec_ready;
   logic [$clog2(QDEPTH):0]     q_count;
`ifdef FETCH_PERF_EN
   logic [31:0]                 perf_fetch_cnt;
   logic [31:0]                 perf_stall_cnt;
   logic [15:0]                 perf_flush_cnt;
`endif

   modport slave (
      input  redirect_valid, redirect_pc, imem_rsp_data, dec_ready,
      output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, q_count
`ifdef FETCH_PERF_EN
      , output perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt
`endif
   );

   modport master (
      output redirect_valid, redirect_pc, imem_rsp_data, dec_ready,
      input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, q_count
`ifdef FETCH_PERF_EN
      , input perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt
`endif
   );
endinterface

// File: rtl/fetch_queue_unit_instr_queue.sv
// Circular instruction queue: FETCH_W-wide enqueue, 0..FETCH_W dequeue, flush.
module instr_queue #(
   parameter int XLEN    = 16,
   parameter int ADDR_W  = 16,
   parameter int FETCH_W = 2,
   parameter int QDEPTH  = 8,
   localparam int PW = $clog2(QDEPTH),
   localparam int CW = PW + 1,
   localparam int NW = $clog2(FETCH_W + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flush_i,
   input  logic                             enq_i,
   input  logic [FETCH_W-1:0][XLEN-1:0]     enq_instr_i,
   input  logic [FETCH_W-1:0][ADDR_W-1:0]   enq_pc_i,
   input  logic [NW-1:0]                    deq_n_i,
   output logic [CW-1:0]                    count_o,
   output logic [FETCH_W-1:0][XLEN-1:0]     head_instr_o,
   output logic [FETCH_W-1:0][ADDR_W-1:0]   head_pc_o
);
   import fetch_pkg::*;

   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [QDEPTH-1:0][XLEN-1:0]   instr_mem_q;
   logic [QDEPTH-1:0][ADDR_W-1:0] pc_mem_q;

   always_comb begin
      head_d  = head_q + PW'(deq_n_i);
      tail_d  = enq_i ? tail_q + PW'(FETCH_W) : tail_q;
      count_d = count_q + (enq_i ? CW'(FETCH_W) : '0) - CW'(deq_n_i);
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload needs no reset: lanes beyond count are masked by the consumer.
   always_ff @(posedge clk) begin
      if (enq_i && !flush_i) begin
         for (int i = 0; i < FETCH_W; i++) begin
            instr_mem_q[tail_q + PW'(i)] <= enq_instr_i[i];
            pc_mem_q[tail_q + PW'(i)]    <= enq_pc_i[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < FETCH_W; i++) begin
         head_instr_o[i] = instr_mem_q[head_q + PW'(i)];
         head_pc_o[i]    = pc_mem_q[head_q + PW'(i)];
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// Multi-issue fetch front end: PC/issue/inflight/kill control around instr_queue.
// Optional perf counters enabled with FETCH_PERF_EN.
module fetch_queue_unit #(
   parameter int XLEN    = fetch_pkg::XLEN,
   parameter int ADDR_W  = fetch_pkg::ADDR_W,
   parameter int FETCH_W = 2,
   parameter int QDEPTH  = 8
) (
   input  logic               clk,
   input  logic               reset,
   fetch_queue_unit_if.slave  bus
);
   import fetch_pkg::*;

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam int NW = $clog2(FETCH_W + 1);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, req_addr_q;
   logic              inflight_q, kill_q;
   logic [CW-1:0]     count;
   logic [FETCH_W-1:0] vld;
   logic [FETCH_W-1:0][XLEN-1:0]   head_instr;
   logic [FETCH_W-1:0][ADDR_W-1:0] head_pc, enq_pc;
   logic [NW-1:0]     deq_n;
   logic              issue, enq;
   int                room;

   // Room counts the in-flight response as already occupying FETCH_W slots.
   always_comb begin
      room  = QDEPTH - int'(count) - (inflight_q ? FETCH_W : 0);
      issue = !reset && !bus.redirect_valid && (room >= FETCH_W);
   end

   assign vld = FETCH_W'(thermo(32'(count)));
   assign enq = inflight_q && !kill_q && !bus.redirect_valid;

   always_comb begin
      deq_n = '0;
      if (bus.dec_ready && vld[0] && !bus.redirect_valid)
         deq_n = (int'(count) >= FETCH_W) ? NW'(FETCH_W) : NW'(count);
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc;
      else if (issue)         fetch_pc_d = fetch_pc_q + ADDR_W'(FETCH_W);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= '0;
         req_addr_q <= '0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         if (issue) req_addr_q <= fetch_pc_q;
         inflight_q <= issue;
         kill_q     <= bus.redirect_valid;
      end
   end

   always_comb begin
      for (int i = 0; i < FETCH_W; i++) enq_pc[i] = req_addr_q + ADDR_W'(i);
   end

   instr_queue #(
      .XLEN(XLEN), .ADDR_W(ADDR_W), .FETCH_W(FETCH_W), .QDEPTH(QDEPTH)
   ) u_queue (
      .clk          (clk),
      .reset        (reset),
      .flush_i      (bus.redirect_valid),
      .enq_i        (enq),
      .enq_instr_i  (bus.imem_rsp_data),
      .enq_pc_i     (enq_pc),
      .deq_n_i      (deq_n),
      .count_o      (count),
      .head_instr_o (head_instr),
      .head_pc_o    (head_pc)
   );

   assign bus.imem_req_valid = issue;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.dec_valid      = vld;
   assign bus.q_count        = count;

   always_comb begin
      bus.dec_instr = {FETCH_W{NOP_INSTR}};
      bus.dec_pc    = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         if (vld[i]) begin
            bus.dec_instr[i*XLEN +: XLEN]   = head_instr[i];
            bus.dec_pc[i*ADDR_W +: ADDR_W]  = head_pc[i];
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_q, perf_stall_q;
   logic [15:0] perf_flush_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (issue && perf_fetch_q != '1) perf_fetch_q <= perf_fetch_q + 32'd1;
         if (vld[0] && !bus.dec_ready && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
         if (bus.redirect_valid && perf_flush_q != '1) perf_flush_q <= perf_flush_q + 16'd1;
      end
   end

   assign bus.perf_fetch_cnt = perf_fetch_q;
   assign bus.perf_stall_cnt = perf_stall_q;
   assign bus.perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed vector table, reset corners, random run vs queue model.
module tb_fetch_queue_unit;
   import fetch_pkg::*;

   localparam int XW = 16, AW = 16, FW = 2, QD = 8, CW = $clog2(QD) + 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_queue_unit_if #(.XLEN(XW), .ADDR_W(AW), .FETCH_W(FW), .QDEPTH(QD)) bus ();

   fetch_queue_unit #(.XLEN(XW), .ADDR_W(AW), .FETCH_W(FW), .QDEPTH(QD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [XW-1:0] memw(input logic [AW-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'h1234;
   endfunction

   // Instruction memory: 1-cycle latency, junk when no request was made.
   always @(posedge clk) begin
      for (int i = 0; i < FW; i++)
         bus.imem_rsp_data[i*XW +: XW] <= bus.imem_req_valid ?
            memw(bus.imem_req_addr + AW'(i)) : 16'hDEAD;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a plain queue of {instr, pc} plus the pending response.
   fetch_entry_t mq[$];
   logic [AW-1:0] m_pc, m_iaddr;
   bit            m_infl;
   int unsigned   m_nfetch, m_nstall, m_nflush;

   task automatic model_reset();
      mq.delete();
      m_pc = '0; m_iaddr = '0; m_infl = 0;
      m_nfetch = 0; m_nstall = 0; m_nflush = 0;
   endtask

   task automatic cycle(input logic rv, input logic [AW-1:0] rpc, input logic rdy);
      logic exp_req;
      logic [FW-1:0]    ev;
      logic [FW*XW-1:0] ei;
      logic [FW*AW-1:0] ep;
      int n;
      @(negedge clk);
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.dec_ready      = rdy;
      #1;
      exp_req = !rv && ((QD - mq.size() - (m_infl ? FW : 0)) >= FW);
      ev = '0; ei = '0; ep = '0;
      for (int i = 0; i < FW; i++) begin
         if (i < mq.size()) begin
            ev[i] = 1'b1;
            ei[i*XW +: XW] = mq[i].instr;
            ep[i*AW +: AW] = mq[i].pc;
         end
      end
      chk("req_valid", bus.imem_req_valid, exp_req);
      if (exp_req) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("dec_valid", bus.dec_valid, ev);
      chk("dec_instr", bus.dec_instr, ei);
      chk("dec_pc", bus.dec_pc, ep);
      chk("q_count", bus.q_count, mq.size());
      if (exp_req) m_nfetch++;
      if (ev[0] && !rdy) m_nstall++;
      if (rv) begin
         mq.delete();
         m_pc = rpc;
         m_infl = 0;
         m_nflush++;
      end else begin
         if (rdy && mq.size() > 0) begin
            n = (mq.size() < FW) ? mq.size() : FW;
            repeat (n) void'(mq.pop_front());
         end
         if (m_infl)
            for (int i = 0; i < FW; i++)
               mq.push_back(fetch_entry_t'{instr: memw(m_iaddr + AW'(i)), pc: m_iaddr + AW'(i)});
         m_infl = exp_req;
         if (exp_req) begin
            m_iaddr = m_pc;
            m_pc    = m_pc + AW'(FW);
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_valid"}, bus.imem_req_valid, 0);
      chk({tag, "_dec_valid"}, bus.dec_valid, 0);
      chk({tag, "_dec_instr"}, bus.dec_instr, 0);
      chk({tag, "_dec_pc"}, bus.dec_pc, 0);
      chk({tag, "_q_count"}, bus.q_count, 0);
   endtask

   typedef struct {
      logic          rv;
      logic [AW-1:0] rpc;
      logic          rdy;
      logic          req;
      logic [AW-1:0] addr;
      int            cnt;
      logic [AW-1:0] pc0, pc1;
   } vec_t;

   vec_t tbl[17];

   initial begin
      // Startup stream, stall to full, redirect with handshake on a full queue,
      // redirect with a response in flight, PC wrap past 0xFFFF.
      tbl[0]  = '{0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000};
      tbl[1]  = '{0, 16'h0000, 1, 1, 16'h0002, 0, 16'h0000, 16'h0000};
      tbl[2]  = '{0, 16'h0000, 1, 1, 16'h0004, 2, 16'h0000, 16'h0001};
      tbl[3]  = '{0, 16'h0000, 1, 1, 16'h0006, 2, 16'h0002, 16'h0003};
      tbl[4]  = '{0, 16'h0000, 0, 1, 16'h0008, 2, 16'h0004, 16'h0005};
      tbl[5]  = '{0, 16'h0000, 0, 1, 16'h000A, 4, 16'h0004, 16'h0005};
      tbl[6]  = '{0, 16'h0000, 0, 0, 16'h0000, 6, 16'h0004, 16'h0005};
      tbl[7]  = '{0, 16'h0000, 0, 0, 16'h0000, 8, 16'h0004, 16'h0005};
      tbl[8]  = '{1, 16'h0040, 1, 0, 16'h0000, 8, 16'h0004, 16'h0005};
      tbl[9]  = '{0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000, 16'h0000};
      tbl[10] = '{0, 16'h0000, 1, 1, 16'h0042, 0, 16'h0000, 16'h0000};
      tbl[11] = '{0, 16'h0000, 1, 1, 16'h0044, 2, 16'h0040, 16'h0041};
      tbl[12] = '{1, 16'hFFFE, 0, 0, 16'h0000, 2, 16'h0042, 16'h0043};
      tbl[13] = '{0, 16'h0000, 1, 1, 16'hFFFE, 0, 16'h0000, 16'h0000};
      tbl[14] = '{0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000};
      tbl[15] = '{0, 16'h0000, 1, 1, 16'h0002, 2, 16'hFFFE, 16'hFFFF};
      tbl[16] = '{0, 16'h0000, 1, 1, 16'h0004, 2, 16'h0000, 16'h0001};

      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.dec_ready      = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk_reset_outputs("reset");
      @(posedge clk);
      #2 reset = 1'b0;
      model_reset();

      for (int k = 0; k < 17; k++) begin
         cycle(tbl[k].rv, tbl[k].rpc, tbl[k].rdy);
         chk($sformatf("tbl%0d_req", k), bus.imem_req_valid, tbl[k].req);
         if (tbl[k].req) chk($sformatf("tbl%0d_addr", k), bus.imem_req_addr, tbl[k].addr);
         chk($sformatf("tbl%0d_count", k), bus.q_count, tbl[k].cnt);
         chk($sformatf("tbl%0d_valid", k), bus.dec_valid,
             (tbl[k].cnt == 0) ? 0 : ((tbl[k].cnt == 1) ? 1 : 3));
         if (tbl[k].cnt > 0) chk($sformatf("tbl%0d_pc", k), bus.dec_pc, {tbl[k].pc1, tbl[k].pc0});
      end

      // Long stall then release: ordering is checked cycle by cycle by the model.
      repeat (10) cycle(1'b0, '0, 1'b0);
      repeat (8)  cycle(1'b0, '0, 1'b1);

      // Randomized traffic with occasional redirects, some near the top of memory.
      for (int k = 0; k < 3000; k++) begin
         logic rv;
         logic [AW-1:0] rpc;
         rv  = ($urandom_range(0, 24) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFC + $urandom_range(0, 3)) : AW'($urandom);
         cycle(rv, rpc, $urandom_range(0, 3) != 0);
      end

      // Reset asserted mid-stream while a response is in flight.
      repeat (6) cycle(1'b0, '0, 1'b1);
      @(posedge clk);
      #3 reset = 1'b1;
      #1 chk_reset_outputs("midreset");
      @(posedge clk);
      #2 reset = 1'b0;
      model_reset();
      repeat (12) cycle(1'b0, '0, $urandom_range(0, 1) != 0);

`ifdef FETCH_PERF_EN
      repeat (20) cycle($urandom_range(0, 9) == 0, AW'($urandom), $urandom_range(0, 1) != 0);
      chk("perf_fetch", bus.perf_fetch_cnt, m_nfetch);
      chk("perf_stall", bus.perf_stall_cnt, m_nstall);
      chk("perf_flush", bus.perf_flush_cnt, m_nflush);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
